// File: rtl/decade_countdown_ctrl.sv
// decade_countdown_ctrl
//   Sequencing controller for a two-digit BCD down-counter. It loads a start
//   value, runs the count at a programmable tick rate (TICK_DIV clock cycles
//   per decrement), and supports pause/resume, abort and terminal-count
//   detection with a single-cycle done pulse.
//
//   Parameters
//     TICK_DIV   clock cycles per decrement, 1..65535
//   Build option
//     COUNTDOWN_AUTORELOAD_EN  when defined, terminal count reloads the digits
//                              and keeps running (unless the reload value is 00)
//   Ports
//     clk, preset           clock; asynchronous active-high preset
//     load, load_tens/ones  capture a new start value (digits >9 clamp to 9)
//     start, pause, abort   single-cycle commands (abort > load > start > pause)
//     tens, ones            current BCD digits
//     busy, paused, done    RUN flag, PAUSE flag, terminal-count pulse
//     state                 encoded FSM state
//
//   state | meaning
//   ------+---------------------------------------------
//   IDLE  | stopped, digits hold last loaded/restored value
//   RUN   | prescaler counting, digits decrement on each tick
//   PAUSE | frozen mid-count, prescaler holds its phase
//   DONE  | terminal count reached, digits hold 00
module decade_countdown_ctrl #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       preset,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       busy,
    output logic       paused,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  rld_tens_q, rld_tens_d;
    logic [3:0]  rld_ones_q, rld_ones_d;
    logic [15:0] presc_q, presc_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        paused_q, paused_d;

    logic        tick;
    logic        terminal;
    logic        digits_zero;
    logic [3:0]  dec_tens, dec_ones;
    logic [3:0]  clamp_tens, clamp_ones;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    always_comb begin
        tick        = (state_q == RUN) && (presc_q == TICK_LAST);
        digits_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
        // 01 is the only value whose decrement lands on 00
        terminal    = tick && (tens_q == 4'd0) && (ones_q == 4'd1);
        clamp_tens  = clamp_bcd(load_tens);
        clamp_ones  = clamp_bcd(load_ones);
        if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
            dec_tens = tens_q;
        end else begin
            dec_ones = 4'd9;
            dec_tens = tens_q - 4'd1;
        end

        state_d    = state_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        rld_tens_d = rld_tens_q;
        rld_ones_d = rld_ones_q;
        presc_d    = presc_q;
        done_d     = 1'b0;

        if (abort) begin
            state_d = IDLE;
            tens_d  = rld_tens_q;
            ones_d  = rld_ones_q;
            presc_d = 16'd0;
        end else if (load && (state_q != RUN)) begin
            rld_tens_d = clamp_tens;
            rld_ones_d = clamp_ones;
            tens_d     = clamp_tens;
            ones_d     = clamp_ones;
            if (state_q == PAUSE) begin
                state_d = IDLE;
            end
        end else if (start && (state_q != RUN)) begin
            if (state_q == PAUSE) begin
                // resume keeps the prescaler phase so pauses cost no run time
                state_d = RUN;
            end else if (!digits_zero) begin
                state_d = RUN;
                presc_d = 16'd0;
            end else begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end else if (state_q == RUN) begin
            // the pause edge still counts as a run cycle, so the prescaler
            // advances (and a coincident tick decrements) before freezing
            if (tick) begin
                presc_d = 16'd0;
                tens_d  = dec_tens;
                ones_d  = dec_ones;
            end else begin
                presc_d = presc_q + 16'd1;
            end
            if (terminal) begin
                done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                if ((rld_tens_q != 4'd0) || (rld_ones_q != 4'd0)) begin
                    tens_d = rld_tens_q;
                    ones_d = rld_ones_q;
                end else begin
                    state_d = DONE;
                end
`else
                state_d = DONE;
`endif
            end else if (pause) begin
                state_d = PAUSE;
            end
        end

        busy_d   = (state_d == RUN);
        paused_d = (state_d == PAUSE);
    end

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state_q    <= IDLE;
            tens_q     <= 4'd9;
            ones_q     <= 4'd9;
            rld_tens_q <= 4'd9;
            rld_ones_q <= 4'd9;
            presc_q    <= 16'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            paused_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            rld_tens_q <= rld_tens_d;
            rld_ones_q <= rld_ones_d;
            presc_q    <= presc_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            paused_q   <= paused_d;
        end
    end

    assign tens   = tens_q;
    assign ones   = ones_q;
    assign busy   = busy_q;
    assign paused = paused_q;
    assign done   = done_q;
    assign state  = state_q;

endmodule

// File: doc/decade_countdown_ctrl.md
# decade_countdown_ctrl

Sequencing controller for a two-digit BCD (decade) down-counter datapath: loads a start value, runs the count at a programmable tick rate, and supports pause/resume, abort and terminal-count detection. It sits between user control logic (buttons/FSMs issuing single-cycle commands) and display/alarm logic that consumes the BCD digits and the `done` pulse. All state is synchronous to `clk`; only `preset` acts asynchronously.

## Interface
Parameters:
- `TICK_DIV`, default 1: clock cycles per count decrement; legal range 1..65535.

Ports:
- `clk`, input, 1: clock; all logic updates on the rising edge.
- `preset`, input, 1: reset; asynchronous, active-high.
- `load`, input, 1: single-cycle command; captures `load_tens`/`load_ones`.
- `load_tens`, input, 4: BCD tens digit to load.
- `load_ones`, input, 4: BCD ones digit to load.
- `start`, input, 1: single-cycle command; start or resume counting.
- `pause`, input, 1: single-cycle command; freeze counting.
- `abort`, input, 1: single-cycle command; return to IDLE.
- `tens`, output, 4: current tens digit, BCD.
- `ones`, output, 4: current ones digit, BCD.
- `busy`, output, 1: high in RUN.
- `paused`, output, 1: high in PAUSE.
- `done`, output, 1: single-cycle pulse on terminal count.
- `state`, output, 2: encoded FSM state.

## Operation
- State encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Reset values while `preset` is high: state IDLE; `tens`=9, `ones`=9; reload register=99; prescaler=0; `busy`=0, `paused`=0, `done`=0.
- Reload register:
  - Holds the last loaded value.
  - Any loaded digit >9 is clamped to 9.
- Command priority, evaluated each edge: `abort` > `load` > `start` > `pause`.
  - Only the highest-priority command that is legal in the current state acts.
- `abort`, any state: go to IDLE; digits are restored from the reload register; prescaler is cleared.
- `load`:
  - Accepted in IDLE, PAUSE and DONE.
  - Writes both the reload register and the digits.
  - In PAUSE, the state goes to IDLE.
  - Ignored in RUN.
- `start`:
  - In IDLE or DONE with digits ≠00: go to RUN and clear the prescaler.
  - In IDLE or DONE with digits =00: go to DONE and pulse `done`.
  - In PAUSE: go to RUN; the prescaler keeps its value.
  - Ignored in RUN.
- `pause`: RUN→PAUSE; the prescaler holds. Ignored in other states.
- Prescaler:
  - Counts 0..TICK_DIV-1, in RUN only.
  - A tick occurs in the cycle where prescaler = TICK_DIV-1; the prescaler then wraps to 0.
- Decrement on tick:
  - If `ones`≠0, then `ones`-1.
  - Otherwise `ones`=9 and `tens`-1.
  - Digits never leave the range 0..9.
- Terminal count:
  - The decrement that produces 00 also moves RUN→DONE.
  - `done`=1 for exactly the following cycle.
- DONE holds 00 until a `load`, `start` or `abort` arrives.

## Timing
- All outputs are registered. A command sampled at edge N is visible after edge N.
- `start` at edge N from value V (≠00):
  - Decrements occur at edges N+k·TICK_DIV, for k=1..V.
  - 00 and state DONE appear after edge N+V·TICK_DIV.
  - `done` is high during the cycle following that edge.
- Pause/resume is cycle-exact:
  - Total RUN cycles to terminal count equal V·TICK_DIV, regardless of pauses.
- A `pause` in the same cycle as a tick does not suppress that tick. The decrement and RUN→PAUSE happen on the same edge.
- A `pause` in the same cycle as the terminal tick: DONE wins, and `done` pulses.
- `abort` in the same cycle as the terminal tick: IDLE wins, digits reload, and there is no `done` pulse.
- `preset` mid-operation: outputs take reset values immediately, without waiting for `clk`. A pending `done` is cancelled.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined:
  - On terminal count, the state stays RUN instead of going to DONE.
  - Digits reload from the reload register on the same edge that would have produced 00.
  - `done` still pulses one cycle per expiry.
  - A reload register of 00 behaves as undefined-macro mode.
- Macro undefined: RUN→DONE with digits 00, as in Operation.

## Test plan
- `preset` pulse mid-RUN → outputs immediately become `tens`=9, `ones`=9, state=0, `busy`=0, `done`=0.
- TICK_DIV=1: load 12, then `start` at edge N:
  - Digits 11,10,09,…,00 at edges N+1..N+12.
  - `done`=1 only in the cycle after N+12; state=3.
- TICK_DIV=4: load 03, `start`, `pause` asserted 6 cycles later, hold paused 10 cycles, then `start` → `done` follows exactly 12 RUN cycles after the first start, with paused cycles excluded. `paused`=1 only while held.
- Load 9F (tens=9, ones=15) → digits read 99. `load` during RUN → ignored.
- Load 05, `start`, `abort` on the terminal tick cycle → state IDLE, digits 05, no `done` pulse. Next: `start` with 00 loaded → state DONE, one `done` pulse.
- With `COUNTDOWN_AUTORELOAD_EN`: load 02, TICK_DIV=1, `start` → sequence 01,02,01,02…; `done` pulses every 2 cycles; `busy` stays 1 until `abort`.
